hangy_guesser: RTL and testbench

HANGY_GUESSER -- requirements
Module: hangy_guesser

---
 rtl/hangy_guesser.sv | 125 ++++++++++++
 tb/tb_hangy_guesser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hangy_guesser.sv
// hangy_guesser: plays a hangman game chip by trying letters 0..LETTER_MAX in order.
// Define HANGY_GUESSER_MISS_COUNT_EN to build the miss counter.
module hangy_guesser #(
  parameter int SETTLE_CYCLES = 8,
  parameter int LETTER_MAX    = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       game_next,
  output logic [4:0] game_char,
  input  logic [4:0] game_guessed,
  input  logic       game_win,
  input  logic       game_lose,
  output logic       busy,
  output logic       done,
  output logic       result_win,
  output logic       exhausted,
  output logic [4:0] cur_letter,
  output logic [2:0] hit_count,
  output logic [3:0] miss_count
);

  localparam int CW = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [3:0] {
    IDLE, ARM, GEN_WAIT, PRESENT, STROBE,
    SETTLE, EVAL, DONE, RESTART
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [4:0]    letter;
  logic [4:0]    snap;
  logic [4:0]    char_q;
  logic [2:0]    hit_q;
  logic          win_q;
  logic          exh_q;
  logic          clr;
  logic          hit_now;
  logic          last;

  assign last    = letter == 5'(LETTER_MAX);
  assign hit_now = game_guessed != snap;
  assign clr     = (state == IDLE && start) ||
                   (state == RESTART && state_n == ARM);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start) state_n = ARM;
      ARM:      state_n = GEN_WAIT;
      GEN_WAIT: if (cnt == CW'(1)) state_n = PRESENT;
      PRESENT:  state_n = STROBE;
      STROBE:   state_n = SETTLE;
      SETTLE:   if (cnt == CW'(SETTLE_CYCLES - 1)) state_n = EVAL;
      EVAL:     state_n = (game_win || game_lose || last) ? DONE : PRESENT;
      DONE:     if (start && !exh_q) state_n = RESTART;
      RESTART:  if (cnt == CW'(1)) state_n = ARM;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      letter <= '0;
      snap   <= '0;
      char_q <= '0;
      hit_q  <= '0;
      win_q  <= 1'b0;
      exh_q  <= 1'b0;
    end else begin
      cnt <= (state_n != state) ? '0 : cnt + 1'b1;
      if (clr) begin
        letter <= '0;
        hit_q  <= '0;
        win_q  <= 1'b0;
        exh_q  <= 1'b0;
      end
      if (state == GEN_WAIT && state_n == PRESENT) char_q <= letter;
      if (state == PRESENT) snap <= game_guessed;
      if (state == EVAL) begin
        if (hit_now && hit_q != 3'd7) hit_q <= hit_q + 3'd1;
        // win is checked first so a simultaneous lose still reports a win
        if (game_win) win_q <= 1'b1;
        else if (game_lose) win_q <= 1'b0;
        else if (last) exh_q <= 1'b1;
        else begin
          letter <= letter + 5'd1;
          char_q <= letter + 5'd1;
        end
      end
    end
  end

`ifdef HANGY_GUESSER_MISS_COUNT_EN
  logic [3:0] miss_q;
  always_ff @(posedge clk) begin
    if (reset || clr) miss_q <= '0;
    else if (state == EVAL && !hit_now && miss_q != 4'd15)
      miss_q <= miss_q + 4'd1;
  end
  assign miss_count = miss_q;
`else
  assign miss_count = '0;
`endif

  assign game_next  = (state == ARM) || (state == STROBE) ||
                      (state == RESTART && cnt == '0);
  assign game_char  = char_q;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = state == DONE;
  assign result_win = win_q;
  assign exhausted  = exh_q;
  assign cur_letter = letter;
  assign hit_count  = hit_q;

endmodule

// File: tb/tb_hangy_guesser.sv
// Bench for hangy_guesser: behavioural hangman game plus a letter-sweep outcome model.
// Honours HANGY_GUESSER_MISS_COUNT_EN for the expected miss count.
module tb_hangy_guesser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       game_next;
  logic [4:0] game_char;
  logic [4:0] game_guessed;
  logic       game_win, game_lose;
  logic       busy, done, result_win, exhausted;
  logic [4:0] cur_letter;
  logic [2:0] hit_count;
  logic [3:0] miss_count;

  int ncmp = 0;
  int nfail = 0;

  logic [4:0] word [5];
  bit         stub = 1'b0;
  bit         both = 1'b0;
  logic [4:0] g_mask = '0;
  int         g_miss = 0;
  int         g_phase = 0;
  int         npulse = 0;
  logic       gn_prev = 1'b0;

  int e_win, e_exh, e_hit, e_miss, e_last, e_strobes;

  always #5 clk = ~clk;

  hangy_guesser dut (
    .clk(clk), .reset(reset), .start(start),
    .game_next(game_next), .game_char(game_char),
    .game_guessed(game_guessed),
    .game_win(game_win), .game_lose(game_lose),
    .busy(busy), .done(done),
    .result_win(result_win), .exhausted(exhausted),
    .cur_letter(cur_letter),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  assign game_guessed = g_mask;
  assign game_win  = both || (!stub && g_mask == 5'h1f);
  assign game_lose = both || (!stub && g_miss >= 8);

  // Game chip: pulse starts a game, then each pulse is a guess; a pulse after the end returns to idle
  always @(posedge clk) begin : game
    logic [4:0] m;
    bit any;
    if (reset) begin
      g_phase <= 0;
      g_mask  <= '0;
      g_miss  <= 0;
    end else if (game_next) begin
      npulse <= npulse + 1;
      if (g_phase != 1) begin
        g_phase <= (g_phase == 0) ? 1 : 0;
        g_mask  <= '0;
        g_miss  <= 0;
      end else begin
        m = g_mask;
        any = 1'b0;
        for (int i = 0; i < 5; i++)
          if (word[i] == game_char) begin
            m[i] = 1'b1;
            any = 1'b1;
          end
        g_mask <= m;
        if (!any) g_miss <= g_miss + 1;
        if (both || (!stub && (m == 5'h1f || g_miss + (any ? 0 : 1) >= 8)))
          g_phase <= 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (gn_prev) check("gn_back_to_back", 32'(game_next), 0);
    gn_prev <= game_next;
  end

  // Outcome of sweeping letters 0..25 against the current word
  task automatic predict();
    bit [4:0] covered;
    int h, m;
    bit any;
    covered = '0;
    h = 0;
    m = 0;
    e_win = 0;
    e_exh = 0;
    e_last = 0;
    e_strobes = 0;
    for (int l = 0; l <= 25; l++) begin
      any = 1'b0;
      for (int i = 0; i < 5; i++)
        if (int'(word[i]) == l && !covered[i]) begin
          covered[i] = 1'b1;
          any = 1'b1;
        end
      if (any) h++;
      else m++;
      e_last = l;
      e_strobes = l + 1;
      if (both || (!stub && covered == 5'h1f)) begin
        e_win = 1;
        break;
      end
      if (!stub && m >= 8) break;
      if (l == 25) e_exh = 1;
    end
    e_hit = (h > 7) ? 7 : h;
`ifdef HANGY_GUESSER_MISS_COUNT_EN
    e_miss = (m > 15) ? 15 : m;
`else
    e_miss = 0;
`endif
  endtask

  task automatic set_word(input int a, b, c, d, e);
    word[0] = 5'(a);
    word[1] = 5'(b);
    word[2] = 5'(c);
    word[3] = 5'(d);
    word[4] = 5'(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_next"}, 32'(game_next), 0);
    check({tag, "_char"}, 32'(game_char), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_win"}, 32'(result_win), 0);
    check({tag, "_exh"}, 32'(exhausted), 0);
    check({tag, "_letter"}, 32'(cur_letter), 0);
    check({tag, "_hit"}, 32'(hit_count), 0);
    check({tag, "_miss"}, 32'(miss_count), 0);
  endtask

  // Start a game (from IDLE or DONE), poke start once mid-game, wait for done
  task automatic run_game(input bit from_done, input string tag);
    int base, n;
    base = npulse;
    n = 0;
    while (n < 2000) begin
      start = (n == 0 || n == 12);
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_first_pulse"}, 32'(game_next), 1);
      if (from_done && n == 2) check({tag, "_gap"}, 32'(game_next), 0);
      if (from_done && n == 3) begin
        check({tag, "_arm_pulse"}, 32'(game_next), 1);
        check({tag, "_hit_clr"}, 32'(hit_count), 0);
        check({tag, "_miss_clr"}, 32'(miss_count), 0);
      end
      if (n > 1 && done) break;
    end
    start = 1'b0;
    predict();
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_win"}, 32'(result_win), e_win);
    check({tag, "_exh"}, 32'(exhausted), e_exh);
    check({tag, "_hit"}, 32'(hit_count), e_hit);
    check({tag, "_miss"}, 32'(miss_count), e_miss);
    check({tag, "_letter"}, 32'(cur_letter), e_last);
    check({tag, "_strobes"}, npulse - base - (from_done ? 2 : 1), e_strobes);
  endtask

  initial begin
    int base, n;
    set_word(0, 1, 2, 3, 4);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_game(1'b0, "win01234");

    set_word(20, 21, 22, 23, 24);
    run_game(1'b1, "lose2024");

    both = 1'b1;
    run_game(1'b1, "both_flags");
    both = 1'b0;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 5; i++) word[i] = 5'($urandom_range(0, 25));
      run_game(1'b1, $sformatf("rnd%0d", k));
    end

    stub = 1'b1;
    set_word(0, 1, 2, 3, 4);
    run_game(1'b1, "stub");
    base = npulse;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("exh_start_done", 32'(done), 1);
    check("exh_start_flag", 32'(exhausted), 1);
    check("exh_start_pulses", npulse - base, 0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stub = 1'b0;
    set_word(20, 21, 22, 23, 24);
    base = npulse;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (npulse - base < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("mid_reached_l3", npulse - base, 5);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    base = npulse;
    repeat (40) @(negedge clk);
    check("post_reset_pulses", npulse - base, 0);
    check("post_reset_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
